ws2812b_pixel_queue: RTL and testbench
======================================

Name: ws2812b_pixel_queue

Overview:
Run-length pixel FIFO between the TinyQV register interface and the ws2812b serializer. Host logic pushes entries of {colour, repeat count, latch flag} without waiting per pixel. The block expands each entry into `count` pixel transfers on the serializer's valid/ready/latch handshake. It asserts latch only on the final pixel of an entry whose latch flag is set.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- COLOR_W, 24, pixel width (GRB order, passed through unchanged).
- CNT_W, 6, repeat-count width.

Ports:
- clk  in  1  system clock (64 MHz nominal)
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  push request
- in_ready  out  1  FIFO not full (level != DEPTH), combinational from level
- in_color  in  COLOR_W  pixel colour
- in_count  in  CNT_W  number of LEDs to emit (0 = accept and discard)
- in_latch  in  1  request latch after the last pixel of this entry
- flush  in  1  one-cycle clear of queued entries and remaining repeats
- led_data  out  COLOR_W  registered pixel to serializer
- led_valid  out  1  registered pixel-valid to serializer
- led_latch  out  1  registered latch qualifier, valid with led_valid
- led_ready  in  1  serializer idle/ready
- level  out  $clog2(DEPTH)+1  queued entries (excludes the active entry)
- busy  out  1  state != IDLE or level != 0
- overflow  out  1  sticky: push attempted while full

Behaviour:
- One clock domain. Reset is synchronous and active-high, with ports clk/reset.
- Reset values: level=0, overflow=0, led_valid=0, led_latch=0, led_data=0, state=IDLE, pointers=0, remaining=0. Reset mid-transfer abandons everything; led_valid=0 on the cycle after reset is sampled.
- Push: occurs when in_valid & in_ready & !flush & in_count!=0. A push with in_count==0 is a no-op: no write, no overflow.
- in_valid & !in_ready sets overflow; the FIFO is unchanged.
- There is no push-while-full, even if a pop occurs the same cycle. Push and pop in the same cycle keep level unchanged.
- FIFO: circular buffer of DEPTH entries of width COLOR_W+CNT_W+1. Read/write pointers wrap modulo DEPTH. The full/empty decision comes from level.
- State machine with active registers act_color, remaining, act_latch:
  - IDLE: led_valid=0. If level!=0 and led_ready=1, pop head into active regs and go to SEND. Same edge: led_valid<=1, led_data<=colour, led_latch<=latch & (count==1), remaining<=count.
  - SEND: led_valid=1. led_data and led_latch stay stable for the whole SEND. When led_ready is sampled 0, the serializer has taken the pixel: led_valid<=0, remaining<=remaining-1, go to GAP.
  - GAP: led_valid=0. Wait for led_ready=1, then:
    - if remaining!=0: led_valid<=1, led_latch<=act_latch & (remaining==1), go to SEND;
    - else if level!=0: pop, go to SEND as in IDLE;
    - else go to IDLE.
- Latency: with the block idle and led_ready=1, a push at edge N gives led_valid=1 after edge N+1, i.e. 2 cycles.
- led_valid never rises while led_ready=0. It never rises in the same cycle it falls.
- Back-to-back entries are emitted with no extra idle cycle beyond GAP.
- flush (priority over push):
  - clears the FIFO: level=0, pointers=0, overflow=0;
  - sets remaining=0 and act_latch=0.
  - A pixel already in SEND completes normally, with its led_latch unchanged. GAP then goes to IDLE.
- Arithmetic: remaining never underflows; the decrement happens only in SEND with remaining>=1.

Optional Feature:
- Macro WS2812B_PIXEL_QUEUE_DIM_EN.
- When defined: adds input dim [1:0]. At pop, each 8-bit channel of the colour is logically right-shifted by dim, and the shifted value is held in act_color/led_data. dim=0 is identity. dim changes only affect later pops.
- When undefined: no dim port; colour passes unchanged.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1 -> level=0, in_ready=1, led_valid=0, overflow=0, busy=0.
- Single entry: serializer model (ready falls 1 cycle after valid, rises 30 cycles later). Push 0x102030, count=3, latch=1 -> first led_valid exactly 2 cycles after push; 3 transfers of 0x102030 with led_latch=0,0,1; then busy=0.
- Ordering/full: hold led_ready=0, push 8 entries (colours 0x01..0x08, count 1) -> level=8, in_ready=0. 9th push -> overflow=1, level stays 8. Release led_ready -> colours emitted 0x01..0x08 in order.
- Zero count: push count=0 colour 0xFFFFFF -> level stays 0, no led_valid, overflow=0.
- Flush: push count=5; after 2 transfers, pulse flush during SEND of the 3rd -> 3rd pixel completes, no further led_valid, level=0, overflow cleared.
- Reset mid-SEND with 3 entries queued -> next cycle led_valid=0, level=0. A later push of count=1 works normally.

Source files
------------

// File: rtl/ws2812b_pixel_queue.sv
// ws2812b_pixel_queue: run-length pixel FIFO feeding the ws2812b serializer.
// Each queued entry {colour, count, latch} expands into `count` pixel
// transfers on the serializer's valid/ready/latch handshake.
// Optional feature macro: WS2812B_PIXEL_QUEUE_DIM_EN (per-channel dim shift at pop).
//
// state | meaning
// IDLE  | no pixel offered, waiting for a queued entry and led_ready
// SEND  | pixel offered (led_valid=1), waiting for led_ready to drop
// GAP   | pixel taken, waiting for led_ready to return before the next one
module ws2812b_pixel_queue #(
  parameter int DEPTH   = 8,
  parameter int COLOR_W = 24,
  parameter int CNT_W   = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [COLOR_W-1:0]         in_color,
  input  logic [CNT_W-1:0]           in_count,
  input  logic                       in_latch,
  input  logic                       flush,
  output logic [COLOR_W-1:0]         led_data,
  output logic                       led_valid,
  output logic                       led_latch,
  input  logic                       led_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       busy,
`ifdef WS2812B_PIXEL_QUEUE_DIM_EN
  input  logic [1:0]                 dim,
`endif
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = COLOR_W + CNT_W + 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t               r_state, w_state_nxt;
  logic [EW-1:0]        r_mem [DEPTH];
  logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]        r_level;
  logic                 r_overflow;
  logic [COLOR_W-1:0]   r_led_data;
  logic                 r_led_valid, r_led_latch;
  logic [CNT_W-1:0]     r_remaining;
  logic                 r_act_latch;

  logic                 w_push, w_pop, w_resend, w_take;
  logic [EW-1:0]        w_head;
  logic [COLOR_W-1:0]   w_head_color;
  logic [CNT_W-1:0]     w_head_cnt;
  logic                 w_head_latch;

  assign in_ready     = (r_level != LW'(DEPTH));
  assign w_push       = in_valid & in_ready & ~flush & (in_count != '0);
  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_cnt   = w_head[CNT_W:1];
  assign w_head_latch = w_head[0];

`ifdef WS2812B_PIXEL_QUEUE_DIM_EN
  function automatic logic [COLOR_W-1:0] f_dim(input logic [COLOR_W-1:0] c,
                                               input logic [1:0] s);
    logic [COLOR_W-1:0] r;
    r = c;
    for (int i = 0; i < COLOR_W / 8; i++) r[i*8 +: 8] = c[i*8 +: 8] >> s;
    return r;
  endfunction
  assign w_head_color = f_dim(w_head[EW-1:CNT_W+1], dim);
`else
  assign w_head_color = w_head[EW-1:CNT_W+1];
`endif

  // Next-state decode; flush suppresses any new pixel but lets SEND finish.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_resend    = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!flush && r_level != '0 && led_ready) begin
          w_pop       = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (!led_ready) begin
          w_take      = 1'b1;
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (flush) begin
          w_state_nxt = IDLE;
        end else if (led_ready) begin
          if (r_remaining != '0) begin
            w_resend    = 1'b1;
            w_state_nxt = SEND;
          end else if (r_level != '0) begin
            w_pop       = 1'b1;
            w_state_nxt = SEND;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_color, in_count, in_latch};
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_push && w_pop) r_level <= r_level - LW'(1);
      if (in_valid && !in_ready) r_overflow <= 1'b1;
    end
  end

  // State register plus the registered pixel interface and active entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_led_data  <= '0;
      r_led_valid <= 1'b0;
      r_led_latch <= 1'b0;
      r_remaining <= '0;
      r_act_latch <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_led_valid <= 1'b1;
        r_led_data  <= w_head_color;
        r_led_latch <= w_head_latch & (w_head_cnt == CNT_W'(1));
        r_remaining <= w_head_cnt;
        r_act_latch <= w_head_latch;
      end else if (w_resend) begin
        r_led_valid <= 1'b1;
        r_led_latch <= r_act_latch & (r_remaining == CNT_W'(1));
      end else if (w_take) begin
        r_led_valid <= 1'b0;
        r_remaining <= r_remaining - CNT_W'(r_remaining != '0);
      end
      if (flush) begin
        r_remaining <= '0;
        r_act_latch <= 1'b0;
      end
    end
  end

  assign led_data  = r_led_data;
  assign led_valid = r_led_valid;
  assign led_latch = r_led_latch;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign busy      = (r_state != IDLE) || (r_level != '0);

endmodule

// File: tb/tb_ws2812b_pixel_queue.sv
// Testbench for ws2812b_pixel_queue: serializer model on led_ready, pixel
// monitor, and an entry-expansion reference model for the pixel stream.
module tb_ws2812b_pixel_queue;

  typedef struct packed {
    logic [23:0] c;
    logic        l;
  } pix_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_color = '0;
  logic [5:0]  in_count = '0;
  logic        in_latch = 1'b0;
  logic        flush = 1'b0;
  logic [23:0] led_data;
  logic        led_valid;
  logic        led_latch;
  logic        led_ready;
  logic [3:0]  level;
  logic        busy;
  logic        overflow;
`ifdef WS2812B_PIXEL_QUEUE_DIM_EN
  logic [1:0]  dim = 2'd0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  bit ser_hold = 1'b0;
  int gap_lo = 30;
  int gap_hi = 30;
  int ser_cnt = 0;

  pix_t obs_q[$];
  pix_t exp_q[$];

  ws2812b_pixel_queue #(.DEPTH(8), .COLOR_W(24), .CNT_W(6)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_color(in_color), .in_count(in_count), .in_latch(in_latch),
    .flush(flush),
    .led_data(led_data), .led_valid(led_valid), .led_latch(led_latch),
    .led_ready(led_ready),
    .level(level), .busy(busy),
`ifdef WS2812B_PIXEL_QUEUE_DIM_EN
    .dim(dim),
`endif
    .overflow(overflow)
  );

  initial forever #5 clk = ~clk;

  // Serializer model: takes a pixel one cycle after valid, then stays busy.
  initial begin
    led_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (ser_hold) begin
        led_ready = 1'b0;
        ser_cnt   = 0;
      end else if (ser_cnt > 0) begin
        ser_cnt = ser_cnt - 1;
        if (ser_cnt == 0) led_ready = 1'b1;
      end else if (led_ready && led_valid) begin
        led_ready = 1'b0;
        ser_cnt   = $urandom_range(gap_hi, gap_lo);
      end else begin
        led_ready = 1'b1;
      end
    end
  end

  // Pixel monitor: every rising edge of led_valid is one offered pixel.
  initial begin
    bit pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (led_valid && !pv) obs_q.push_back('{c: led_data, l: led_latch});
      pv = led_valid;
    end
  end

  task automatic push(input logic [23:0] c, input logic [5:0] n, input logic l);
    @(negedge clk);
    in_valid = 1'b1; in_color = c; in_count = n; in_latch = l;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push_rdy(input logic [23:0] c, input logic [5:0] n, input logic l,
                          output bit ok);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 500) begin @(negedge clk); t++; end
    ok = in_ready;
    in_valid = 1'b1; in_color = c; in_count = n; in_latch = l;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    int t;
    t = 0; ok = 1'b0;
    while (t < budget && !ok) begin
      @(negedge clk); t++;
      if (!busy && !led_valid && obs_q.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_count = 6'd1; in_color = 24'h123456;
    repeat (2) @(negedge clk);
    n_cmp++; if (level !== 4'd0)    begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (led_valid !== 1'b0) begin n_bad++; $display("FAIL reset_led_valid: got %b want 0", led_valid); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    gap_lo = 30; gap_hi = 30;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back('{c: 24'h102030, l: (i == 2)});
    push(24'h102030, 6'd3, 1'b1);
    n_cmp++; if (led_valid !== 1'b0) begin n_bad++; $display("FAIL single_lat1: got %b want 0", led_valid); end
    @(negedge clk);
    n_cmp++; if (led_valid !== 1'b1) begin n_bad++; $display("FAIL single_lat2: got %b want 1", led_valid); end
    wait_done(3, 400, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_timeout: got %0d pixels want 3", obs_q.size()); end
    n_cmp++; if (obs_q.size() !== 3) begin n_bad++; $display("FAIL single_count: got %0d want 3", obs_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL single_pix%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy: got %b want 0", busy); end
  endtask

  task automatic test_order_full();
    bit ok;
    gap_lo = 2; gap_hi = 2;
    ser_hold = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 8; i++) push(24'(i), 6'd1, 1'b0);
    n_cmp++; if (level !== 4'd8)    begin n_bad++; $display("FAIL full_level: got %0d want 8", level); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    push(24'h000009, 6'd1, 1'b0);
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL full_overflow: got %b want 1", overflow); end
    n_cmp++; if (level !== 4'd8)    begin n_bad++; $display("FAIL full_level_kept: got %0d want 8", level); end
    obs_q.delete();
    ser_hold = 1'b0;
    wait_done(8, 400, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL order_timeout: got %0d pixels want 8", obs_q.size()); end
    n_cmp++; if (obs_q.size() !== 8) begin n_bad++; $display("FAIL order_count: got %0d want 8", obs_q.size()); end
    for (int i = 0; i < 8; i++) begin
      pix_t e;
      e = '{c: 24'(i + 1), l: 1'b0};
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== e) begin
        n_bad++; $display("FAIL order_pix%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, e);
      end
    end
  endtask

  task automatic test_flush();
    int rises, t;
    bit pv;
    gap_lo = 6; gap_hi = 6;
    obs_q.delete();
    push(24'hA0B0C0, 6'd5, 1'b1);
    rises = 0; t = 0; pv = led_valid;
    while (rises < 3 && t < 300) begin
      @(negedge clk); t++;
      if (led_valid && !pv) rises++;
      pv = led_valid;
    end
    n_cmp++; if (rises != 3) begin n_bad++; $display("FAIL flush_reach3: got %0d rises want 3", rises); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++; if (obs_q.size() !== 3) begin n_bad++; $display("FAIL flush_pixels: got %0d want 3", obs_q.size()); end
    for (int i = 0; i < 3; i++) begin
      pix_t e;
      e = '{c: 24'hA0B0C0, l: 1'b0};
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== e) begin
        n_bad++; $display("FAIL flush_pix%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, e);
      end
    end
    n_cmp++; if (level !== 4'd0)    begin n_bad++; $display("FAIL flush_level: got %0d want 0", level); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL flush_overflow: got %b want 0", overflow); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL flush_busy: got %b want 0", busy); end
  endtask

  task automatic test_zero_count();
    obs_q.delete();
    push(24'hFFFFFF, 6'd0, 1'b1);
    repeat (6) @(negedge clk);
    n_cmp++; if (level !== 4'd0)       begin n_bad++; $display("FAIL zero_level: got %0d want 0", level); end
    n_cmp++; if (obs_q.size() !== 0)   begin n_bad++; $display("FAIL zero_pixels: got %0d want 0", obs_q.size()); end
    n_cmp++; if (overflow !== 1'b0)    begin n_bad++; $display("FAIL zero_overflow: got %b want 0", overflow); end
    n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL zero_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t;
    gap_lo = 3; gap_hi = 3;
    ser_hold = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 4; i++) push(24'(i * 24'h111111), 6'd2, 1'b1);
    ser_hold = 1'b0;
    t = 0;
    while (!led_valid && t < 50) begin @(negedge clk); t++; end
    n_cmp++; if (level !== 4'd3) begin n_bad++; $display("FAIL rmid_queued: got %0d want 3", level); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (led_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b want 0", led_valid); end
    n_cmp++; if (level !== 4'd0)     begin n_bad++; $display("FAIL rmid_level: got %0d want 0", level); end
    repeat (8) @(negedge clk);
    obs_q.delete();
    push(24'h55AA33, 6'd1, 1'b1);
    wait_done(1, 200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmid_timeout: got %0d pixels want 1", obs_q.size()); end
    n_cmp++;
    if (obs_q.size() != 1 || obs_q[0] !== pix_t'{c: 24'h55AA33, l: 1'b1}) begin
      n_bad++; $display("FAIL rmid_after: got %0d pixels first %h want 1 pixel %h", obs_q.size(),
                        (obs_q.size() > 0) ? obs_q[0] : '0, pix_t'{c: 24'h55AA33, l: 1'b1});
    end
  endtask

  task automatic test_random();
    bit ok, all_ok;
    logic [23:0] c;
    logic [5:0]  n;
    logic        l;
    gap_lo = 1; gap_hi = 4;
    obs_q.delete(); exp_q.delete();
    all_ok = 1'b1;
    for (int e = 0; e < 30; e++) begin
      c = 24'($urandom);
      n = 6'($urandom_range(0, 4));
      l = 1'($urandom_range(0, 1));
      for (int k = 1; k <= int'(n); k++) exp_q.push_back('{c: c, l: l && (k == int'(n))});
      push_rdy(c, n, l, ok);
      all_ok &= ok;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    n_cmp++; if (!all_ok) begin n_bad++; $display("FAIL rand_push_timeout: got stalled push want accepted"); end
    wait_done(exp_q.size(), 3000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rand_timeout: got %0d pixels want %0d", obs_q.size(), exp_q.size()); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL rand_pix%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rand_overflow: got %b want 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_order_full();
    test_flush();
    test_zero_count();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
